// File: rtl/dense_sequencer.sv
// Sequencer for one fully-connected layer: per neuron, a bias read, IN_LEN
// time-multiplexed signed MACs, then rescale, saturate, optional ReLU and write.
module dense_sequencer #(
  parameter int  IN_LEN    = 784,
  parameter int  OUT_LEN   = 128,
  parameter int  DATA_W    = 16,
  parameter int  FRAC_BITS = 8,
  parameter int  ACC_W     = 48,
  parameter bit  RELU      = 1'b1,
  localparam int IA_W      = (IN_LEN > 1) ? $clog2(IN_LEN) : 1,
  localparam int WA_W      = (IN_LEN * OUT_LEN > 1) ? $clog2(IN_LEN * OUT_LEN) : 1,
  localparam int BA_W      = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [IA_W-1:0]   in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic [WA_W-1:0]   w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [BA_W-1:0]   b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              out_we,
  output logic [BA_W-1:0]   out_addr,
  output logic [DATA_W-1:0] out_data
);

  if (ACC_W < 2 * DATA_W + $clog2(IN_LEN) + 1) begin : g_acc_width_check
    $error("dense_sequencer: ACC_W too narrow for IN_LEN products");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_e                   state_q, state_d;
  logic [BA_W-1:0]          o_q, o_d;
  logic [IA_W-1:0]          j_q, j_d;
  logic [WA_W-1:0]          w_addr_q, w_addr_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [ACC_W-1:0]    shifted;
  logic [DATA_W-1:0]          sat_val;
  logic [DATA_W-1:0]          result;

  // Operands arriving this cycle belong to the read issued on the previous cycle.
  assign prod     = $signed(in_data) * $signed(w_data);
  assign prod_ext = ACC_W'(prod);
  assign bias_ext = ACC_W'($signed(b_data)) <<< FRAC_BITS;

  always_comb begin
    shifted = acc_q >>> FRAC_BITS;
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN[DATA_W-1:0];
    end else begin
      sat_val = shifted[DATA_W-1:0];
    end
    result = (RELU && sat_val[DATA_W-1]) ? '0 : sat_val;
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
    state_d  = state_q;
    o_d      = o_q;
    j_d      = j_q;
    w_addr_d = w_addr_q;
    acc_d    = acc_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            o_d      = '0;
            w_addr_d = '0;
            state_d  = S_BIAS;
          end
        end
        S_BIAS: begin
          j_d = '0;
          // w_addr holds the last issued weight; step onto this neuron's row.
          if (o_q != '0) w_addr_d = w_addr_q + WA_W'(1);
          state_d = S_MAC;
        end
        S_MAC: begin
          acc_d = (j_q == '0) ? bias_ext : acc_q + prod_ext;
          if (j_q == IA_W'(IN_LEN - 1)) begin
            state_d = S_DRAIN;
          end else begin
            j_d      = j_q + IA_W'(1);
            w_addr_d = w_addr_q + WA_W'(1);
          end
        end
        S_DRAIN: begin
          acc_d   = acc_q + prod_ext;
          state_d = S_WRITE;
        end
        S_WRITE: begin
          if (o_q == BA_W'(OUT_LEN - 1)) begin
            state_d = S_DONE;
          end else begin
            o_d     = o_q + BA_W'(1);
            state_d = S_BIAS;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      o_q      <= '0;
      j_q      <= '0;
      w_addr_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      o_q      <= o_d;
      j_q      <= j_d;
      w_addr_q <= w_addr_d;
      acc_q    <= acc_d;
    end
  end

  assign busy     = (state_q == S_BIAS) || (state_q == S_MAC) ||
                    (state_q == S_DRAIN) || (state_q == S_WRITE);
  assign done     = (state_q == S_DONE) && !abort;
  assign rd_en    = (state_q == S_BIAS) || (state_q == S_MAC);
  assign in_addr  = j_q;
  assign w_addr   = w_addr_q;
  assign b_addr   = o_q;
  assign out_we   = (state_q == S_WRITE) && !abort;
  assign out_addr = o_q;
  assign out_data = out_we ? result : '0;

endmodule

// File: tb/tb_dense_sequencer.sv
// Scoreboard bench: two sequencers (RELU=1 and RELU=0) share stimulus; expected
// writes are queued per pass and popped by per-instance write monitors.
module tb_dense_sequencer;
  localparam int IN_LEN  = 4;
  localparam int OUT_LEN = 3;
  localparam int DW      = 16;
  localparam int IA_W    = 2;
  localparam int WA_W    = 4;
  localparam int BA_W    = 2;

  typedef struct {
    logic [BA_W-1:0]      addr;
    logic signed [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;

  logic                 busy1, done1, rd1, we1;
  logic [IA_W-1:0]      ia1;
  logic [WA_W-1:0]      wa1;
  logic [BA_W-1:0]      ba1, oa1;
  logic [DW-1:0]        in_d1, w_d1, b_d1;
  logic signed [DW-1:0] od1;

  logic                 busy0, done0, rd0, we0;
  logic [IA_W-1:0]      ia0;
  logic [WA_W-1:0]      wa0;
  logic [BA_W-1:0]      ba0, oa0;
  logic [DW-1:0]        in_d0, w_d0, b_d0;
  logic signed [DW-1:0] od0;

  logic signed [DW-1:0] x_mem [IN_LEN];
  logic signed [DW-1:0] w_mem [IN_LEN*OUT_LEN];
  logic signed [DW-1:0] b_mem [OUT_LEN];
  logic signed [DW-1:0] e1 [OUT_LEN];
  logic signed [DW-1:0] e0 [OUT_LEN];

  wr_t q1[$];
  wr_t q0[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dense_sequencer #(
    .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .DATA_W(DW), .FRAC_BITS(8), .ACC_W(48), .RELU(1'b1)
  ) u_dut1 (
    .clock(clk), .reset_n(rst_n), .start(start), .abort(abort),
    .busy(busy1), .done(done1), .rd_en(rd1),
    .in_addr(ia1), .in_data(in_d1), .w_addr(wa1), .w_data(w_d1),
    .b_addr(ba1), .b_data(b_d1),
    .out_we(we1), .out_addr(oa1), .out_data(od1)
  );

  dense_sequencer #(
    .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .DATA_W(DW), .FRAC_BITS(8), .ACC_W(48), .RELU(1'b0)
  ) u_dut0 (
    .clock(clk), .reset_n(rst_n), .start(start), .abort(abort),
    .busy(busy0), .done(done0), .rd_en(rd0),
    .in_addr(ia0), .in_data(in_d0), .w_addr(wa0), .w_data(w_d0),
    .b_addr(ba0), .b_data(b_d0),
    .out_we(we0), .out_addr(oa0), .out_data(od0)
  );

  // One-cycle-latency memories, one read port per instance.
  always @(posedge clk) begin
    if (rd1) begin
      in_d1 <= x_mem[ia1];
      w_d1  <= w_mem[wa1];
      b_d1  <= b_mem[ba1];
    end
    if (rd0) begin
      in_d0 <= x_mem[ia0];
      w_d0  <= w_mem[wa0];
      b_d0  <= b_mem[ba0];
    end
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon1
    wr_t e;
    if (we1 === 1'b1) begin
      if (q1.size() == 0) begin
        check("relu_unexpected_write", 1, 0);
      end else begin
        e = q1.pop_front();
        check("relu_out_addr", oa1, e.addr);
        check("relu_out_data", od1, e.data);
      end
    end
  end

  always @(negedge clk) begin : mon0
    wr_t e;
    if (we0 === 1'b1) begin
      if (q0.size() == 0) begin
        check("norelu_unexpected_write", 1, 0);
      end else begin
        e = q0.pop_front();
        check("norelu_out_addr", oa0, e.addr);
        check("norelu_out_data", od0, e.data);
      end
    end
  end

  task automatic fill(input logic signed [DW-1:0] x, input logic signed [DW-1:0] w,
                      input logic signed [DW-1:0] b, input logic signed [DW-1:0] r1,
                      input logic signed [DW-1:0] r0);
    for (int i = 0; i < IN_LEN; i++) x_mem[i] = x;
    for (int i = 0; i < IN_LEN * OUT_LEN; i++) w_mem[i] = w;
    for (int i = 0; i < OUT_LEN; i++) begin
      b_mem[i] = b;
      e1[i]    = r1;
      e0[i]    = r0;
    end
  endtask

  // Features 1, 2, -1, 0.5; neuron 1 lands on -127.5 and must floor to -128.
  task automatic fill_mixed();
    x_mem[0] = 16'sd256;  x_mem[1] = 16'sd512;  x_mem[2] = -16'sd256; x_mem[3] = 16'sd128;
    for (int i = 0; i < 4; i++) w_mem[i] = 16'sd256;
    w_mem[4] = 16'sd128;  w_mem[5] = -16'sd128; w_mem[6] = 16'sd256;  w_mem[7] = 16'sd1;
    for (int i = 8; i < 12; i++) w_mem[i] = -16'sd256;
    b_mem[0] = 16'sd0;    b_mem[1] = 16'sd256;  b_mem[2] = 16'sd1024;
    e1[0] = 16'sd640;     e1[1] = 16'sd0;       e1[2] = 16'sd384;
    e0[0] = 16'sd640;     e0[1] = -16'sd128;    e0[2] = 16'sd384;
  endtask

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++) begin
      q1.push_back('{addr: BA_W'(i), data: e1[i]});
      q0.push_back('{addr: BA_W'(i), data: e0[i]});
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dut1_outputs"}, {busy1, done1, rd1, we1, ia1, wa1, ba1, oa1, od1}, 0);
    check({tag, "_dut0_outputs"}, {busy0, done0, rd0, we0, ia0, wa0, ba0, oa0, od0}, 0);
  endtask

  // k counts cycles after the edge that samples start; the BIAS cycle is k=0.
  task automatic run_pass(input int repulse_k, input int abort_k, input int reset_k,
                          input bit chk_addr);
    int busy_cnt;
    int done_k;
    int ph;
    int o;
    busy_cnt = 0;
    done_k   = -1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (busy1 === 1'b1) busy_cnt++;
      if (done1 === 1'b1 && done_k < 0) done_k = k;
      if (abort_k >= 0 && k == abort_k + 1) check("busy_after_abort", busy1, 0);
      if (chk_addr && k < 21) begin
        ph = k % 7;
        o  = k / 7;
        check("rd_en", rd1, (ph <= 4) ? 1 : 0);
        if (ph == 0) check("b_addr", ba1, o);
        if (ph >= 1 && ph <= 4) begin
          check("in_addr", ia1, ph - 1);
          check("w_addr", wa1, o * IN_LEN + ph - 1);
        end
      end
      if (k == reset_k) begin
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        break;
      end
      start = (k == repulse_k);
      abort = (k == abort_k);
      if (done_k >= 0) break;
    end
    start = 1'b0;
    abort = 1'b0;
    if (abort_k < 0 && reset_k < 0) begin
      check("done_cycle", done_k, 21);
      check("busy_cycles", busy_cnt, 21);
      check("norelu_done_in_step", done0, 1);
    end else begin
      check("no_done", done_k, -1);
    end
  endtask

  initial begin
    fill(16'sd256, 16'sd128, 16'sd0, 16'sd512, 16'sd512);
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;

    // Basic run plus address-sequence checks.
    push_exp(3);
    run_pass(-1, -1, -1, 1'b1);

    fill(16'sd256, -16'sd256, 16'sd256, 16'sd0, -16'sd768);
    push_exp(3);
    run_pass(-1, -1, -1, 1'b0);

    fill(16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767);
    push_exp(3);
    run_pass(-1, -1, -1, 1'b0);

    fill(16'sd32767, -16'sd32768, 16'sd32767, 16'sd0, -16'sd32768);
    push_exp(3);
    run_pass(-1, -1, -1, 1'b0);

    fill_mixed();
    push_exp(3);
    run_pass(-1, -1, -1, 1'b0);

    // start re-pulsed mid-pass must not disturb the pass.
    fill(16'sd256, 16'sd128, 16'sd0, 16'sd512, 16'sd512);
    push_exp(3);
    run_pass(5, -1, -1, 1'b0);

    // Abort in neuron 1 MAC: only neuron 0 is written.
    fill_mixed();
    push_exp(1);
    run_pass(-1, 9, -1, 1'b0);
    check("abort_queue_drained", q1.size(), 0);

    push_exp(3);
    run_pass(-1, -1, -1, 1'b0);

    // Async reset in neuron 2 MAC, then a clean pass.
    fill(16'sd256, 16'sd128, 16'sd0, 16'sd512, 16'sd512);
    push_exp(2);
    run_pass(-1, -1, 16, 1'b0);
    @(negedge clk);
    check_all_zero("held_in_reset");
    rst_n = 1'b1;
    push_exp(3);
    run_pass(-1, -1, -1, 1'b1);

    repeat (3) @(negedge clk);
    check("relu_queue_empty", q1.size(), 0);
    check("norelu_queue_empty", q0.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dense_sequencer.md
# dense_sequencer

Control and MAC sequencer for one fully-connected layer. On `start`, it computes every output neuron in turn by walking the input-feature buffer and weight/bias memories. Per neuron it runs a single time-multiplexed signed multiply-accumulate, adds the bias, then rescales, saturates and optionally applies ReLU. Each result is written into an output buffer. It sits between the layer's receive buffer, which is filled by the input handshake logic, and the transmit logic, which streams the output buffer once `done` pulses.

## Interface
Parameters:
- `IN_LEN`, 784: input vector length.
- `OUT_LEN`, 128: output neuron count.
- `DATA_W`, 16: signed fixed-point width of features, weights and biases.
- `FRAC_BITS`, 8: fractional bits of all data.
- `ACC_W`, 48: signed accumulator width. Must be ≥ 2*DATA_W + $clog2(IN_LEN) + 1; checked by elaboration assertion.
- `RELU`, 1: when 1, clamp negative results to 0.

Ports:
- `clock` in 1: single clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a layer pass; accepted only in IDLE.
- `abort` in 1: synchronous cancel of a pass in progress.
- `busy` out 1: high from BIAS through WRITE.
- `done` out 1: one-cycle pulse when the whole layer is written.
- `rd_en` out 1: read strobe for the input, weight and bias memories.
- `in_addr` out $clog2(IN_LEN): input buffer read address.
- `in_data` in DATA_W: input feature, valid 1 cycle after `rd_en`.
- `w_addr` out $clog2(IN_LEN*OUT_LEN): weight address, row-major, = o*IN_LEN + j.
- `w_data` in DATA_W: weight, valid 1 cycle after `rd_en`.
- `b_addr` out $clog2(OUT_LEN): bias address.
- `b_data` in DATA_W: bias, valid 1 cycle after `rd_en`.
- `out_we` out 1: output buffer write strobe.
- `out_addr` out $clog2(OUT_LEN): output index.
- `out_data` out DATA_W: result value.

## Operation
- **States:** IDLE, BIAS, MAC, DRAIN, WRITE, DONE. Counters: neuron index `o`, input index `j`. `w_addr` is a running counter; no multiplier is used for it.
- **IDLE:** on `start`, set `o`=0 and `w_addr`=0, then go to BIAS.
- **BIAS (1 cycle):** `rd_en`=1, `b_addr`=o, `j`=0, then go to MAC.
- **MAC (IN_LEN cycles):**
  - Each cycle: `rd_en`=1, `in_addr`=j, `w_addr`++ after issue, `j`++.
  - On the first MAC cycle, load `acc` with `b_data` sign-extended and shifted left by FRAC_BITS.
  - On every following cycle, and in DRAIN, add the `in_data`*`w_data` signed full-width product from the previous read to `acc`.
  - Leave MAC after issuing `j`=IN_LEN-1.
- **DRAIN (1 cycle):** `rd_en`=0; accumulate the last product.
- **WRITE (1 cycle):**
  - `result` = `acc` >>> FRAC_BITS (arithmetic shift, truncation toward −inf).
  - Saturate `result` to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - If RELU and `result` < 0, force 0.
  - Assert `out_we`=1, `out_addr`=o, `out_data`=result.
  - If `o`=OUT_LEN−1, go to DONE; otherwise `o`++ and go to BIAS.
- **DONE (1 cycle):** `done`=1, then go to IDLE.
- **`start` outside IDLE** (including DONE) is ignored; no queuing.
- **`abort`:** in any non-IDLE state, go to IDLE next edge. Any pending write is suppressed, `done` is not asserted, and the output buffer keeps its partial contents. `abort` takes priority over state transitions. `abort` together with `start` in IDLE: remain IDLE.
- **Reset:** `reset_n` low at any time forces IDLE immediately. All outputs become 0 (`busy`, `done`, `rd_en`, `out_we`, all addresses, `out_data`). `acc`, `o` and `j` are cleared.

## Timing
- **Memory read latency:** exactly 1 cycle; data is sampled on the edge after `rd_en`.
- **Cycles per neuron:** IN_LEN+3 (BIAS + IN_LEN MAC + DRAIN + WRITE).
- **`done` timing:** `start` is sampled at edge E0; `done` is high during the cycle starting at E0 + OUT_LEN*(IN_LEN+3). Earliest next accepted `start` is 2 cycles after the final WRITE.
- **`busy`:** rises on E0 and falls at entry to DONE.
- **`out_we`:** high exactly OUT_LEN times per pass, once per neuron, with `out_addr` ascending 0..OUT_LEN−1.
- **Address stability:** `in_addr`, `w_addr` and `b_addr` are registered outputs and hold their last value when `rd_en`=0.

## Test plan
Bench parameters unless noted: IN_LEN=4, OUT_LEN=3, DATA_W=16, FRAC_BITS=8, RELU=1.

- **Basic:** all inputs 256 (1.0), weights 128 (0.5), biases 0, `start` pulse → three writes of 512 to addresses 0,1,2; `done` 21 cycles after the start edge; `busy` high for 21 cycles.
- **Address sequence:** same run → `w_addr` 0..11 contiguous in MAC cycles, `in_addr` 0,1,2,3 repeating, `b_addr` 0,1,2, one `rd_en` gap (DRAIN) per neuron.
- **ReLU and sign:** inputs 256, weights −256, bias 256 → result −768 clamps to 0. With RELU=0 the same stimulus writes −768 (0xFD00).
- **Saturation:**
  - RELU=0, inputs 32767, weights 32767, biases 32767 → 32767 at every address.
  - RELU=0, weights −32768, same inputs and biases → −32768.
- **Control corners:**
  - `start` re-pulsed mid-pass → ignored; timing unchanged.
  - `abort` during MAC of neuron 1 → IDLE next edge; no further `out_we`; no `done`.
  - A subsequent `start` completes a correct full pass.
- **Reset mid-pass:** drop `reset_n` asynchronously during neuron 2 MAC → all outputs 0 immediately, FSM in IDLE; after release, a new `start` gives correct results and `done` at 21 cycles.
